// File: rtl/fifo18_rx_arbiter_if.sv
// fifo18_rx_arbiter_if
//   Bundles the two upstream FWFT RX FIFO read ports and the downstream
//   18-bit FIFO write port of fifo18_rx_arbiter.
//   Signals:
//     rx0_dout[17:0], rx0_empty, rx0_rd_en  port0 FIFO read side
//     rx1_dout[17:0], rx1_empty, rx1_rd_en  port1 FIFO read side
//     tx_din[17:0], tx_wr_en, tx_src        merged write toward downstream FIFO
//     tx_full                               downstream almost-full
//   Modports:
//     master : the arbiter (pops rx FIFOs, writes tx FIFO)
//     slave  : the surrounding FIFOs
interface fifo18_rx_arbiter_if;
  logic [17:0] rx0_dout;
  logic        rx0_empty;
  logic        rx0_rd_en;
  logic [17:0] rx1_dout;
  logic        rx1_empty;
  logic        rx1_rd_en;
  logic [17:0] tx_din;
  logic        tx_full;
  logic        tx_wr_en;
  logic        tx_src;

  modport master (
    input  rx0_dout, rx0_empty, rx1_dout, rx1_empty, tx_full,
    output rx0_rd_en, rx1_rd_en, tx_din, tx_wr_en, tx_src
  );

  modport slave (
    output rx0_dout, rx0_empty, rx1_dout, rx1_empty, tx_full,
    input  rx0_rd_en, rx1_rd_en, tx_din, tx_wr_en, tx_src
  );
endinterface

// File: rtl/fifo18_rx_arbiter.sv
// fifo18_rx_arbiter
//   Packet-granular round-robin arbiter merging two FWFT receive FIFOs into
//   one downstream 18-bit FIFO. Frames are never interleaved; a word whose
//   flags [17:16] are 2'b00 terminates a frame. Frames longer than MAX_WORDS
//   are cut: MAX_WORDS words are forwarded, an 18'h00000 terminator is
//   injected and the rest of the source frame is popped and discarded.
//   Ports:
//     sys_clk  single rising-edge clock
//     sys_rst  asynchronous active-high reset
//     bus      fifo18_rx_arbiter_if.master (rx0/rx1 read, tx write)
//     stat_frames0/1[31:0], stat_trunc[15:0]  only with ARB_STATS_EN defined
//   Parameters:
//     MAX_WORDS  max words per frame before truncation (2..4095)
//   Build option:
//     ARB_STATS_EN  adds per-port frame counters and a truncation counter
module fifo18_rx_arbiter #(
  parameter int unsigned MAX_WORDS = 760
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  fifo18_rx_arbiter_if.master   bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           stat_frames0,
  output logic [31:0]           stat_frames1,
  output logic [15:0]           stat_trunc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_TRUNC, S_DROP} state_t;

  localparam logic [11:0] LP_MAX = 12'(MAX_WORDS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic        w_grant_nxt;
  logic        r_last_grant;
  logic [11:0] r_cnt;
  logic [17:0] r_tx_din;
  logic        r_tx_wr_en;
  logic        r_tx_src;

  logic [17:0] w_sel_dout;
  logic        w_sel_empty;
  logic        w_term;
  logic        w_last_word;
  logic        w_pop;
  logic        w_wr;
  logic [17:0] w_din_nxt;

  assign w_sel_dout  = r_grant ? bus.rx1_dout  : bus.rx0_dout;
  assign w_sel_empty = r_grant ? bus.rx1_empty : bus.rx0_empty;
  assign w_term      = (w_sel_dout[17:16] == 2'b00);
  assign w_last_word = ((r_cnt + 12'd1) == LP_MAX);

  // State and datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_tx_din     <= '0;
      r_tx_wr_en   <= 1'b0;
      r_tx_src     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_tx_wr_en <= w_wr;
      r_tx_din   <= w_din_nxt;
      if (w_wr)
        r_tx_src <= r_grant;
      if (r_state == S_IDLE)
        r_cnt <= '0;
      else if (r_state == S_XFER && w_pop)
        r_cnt <= r_cnt + 12'd1;
      // pops only happen in XFER/DROP, so a popped terminator always ends the frame
      if (w_pop && w_term)
        r_last_grant <= r_grant;
    end
  end

  // Next-state / grant selection
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.rx0_empty && !bus.rx1_empty) begin
          w_grant_nxt = ~r_last_grant;
          w_state_nxt = S_XFER;
        end else if (!bus.rx0_empty) begin
          w_grant_nxt = 1'b0;
          w_state_nxt = S_XFER;
        end else if (!bus.rx1_empty) begin
          w_grant_nxt = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_pop) begin
          if (w_term)
            w_state_nxt = S_IDLE;
          else if (w_last_word)
            w_state_nxt = S_TRUNC;
        end
      end
      S_TRUNC: begin
        if (!bus.tx_full)
          w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (w_pop && w_term)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pops and next values for the registered tx outputs
  always_comb begin
    w_pop     = 1'b0;
    w_wr      = 1'b0;
    w_din_nxt = r_tx_din;
    unique case (r_state)
      S_XFER: begin
        w_pop = !w_sel_empty && !bus.tx_full;
        w_wr  = w_pop;
        if (w_pop)
          w_din_nxt = w_sel_dout;
      end
      S_TRUNC: begin
        w_wr = !bus.tx_full;
        if (w_wr)
          w_din_nxt = '0;
      end
      // discard path ignores tx_full: nothing is written downstream
      S_DROP:  w_pop = !w_sel_empty;
      default: ;
    endcase
  end

  assign bus.rx0_rd_en = w_pop && !r_grant;
  assign bus.rx1_rd_en = w_pop &&  r_grant;
  assign bus.tx_din    = r_tx_din;
  assign bus.tx_wr_en  = r_tx_wr_en;
  assign bus.tx_src    = r_tx_src;

`ifdef ARB_STATS_EN
  logic        w_term_wr;
  logic        w_trunc_entry;
  logic [31:0] r_frames0;
  logic [31:0] r_frames1;
  logic [15:0] r_trunc;

  // a terminator reaches the downstream FIFO either forwarded or injected
  assign w_term_wr     = (r_state == S_XFER && w_pop && w_term) ||
                         (r_state == S_TRUNC && w_wr);
  assign w_trunc_entry = (r_state == S_XFER && w_pop && !w_term && w_last_word);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_frames0 <= '0;
      r_frames1 <= '0;
      r_trunc   <= '0;
    end else begin
      if (w_term_wr && !r_grant)
        r_frames0 <= r_frames0 + 32'd1;
      if (w_term_wr && r_grant)
        r_frames1 <= r_frames1 + 32'd1;
      if (w_trunc_entry)
        r_trunc <= r_trunc + 16'd1;
    end
  end

  assign stat_frames0 = r_frames0;
  assign stat_frames1 = r_frames1;
  assign stat_trunc   = r_trunc;
`endif

endmodule
